// File: rtl/zap_wb_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : zap_wb_arbiter_n
//  Description : N-master Wishbone arbiter with a registered slave-side bus,
//                fixed-priority or round-robin arbitration, a bus lock that
//                holds across bursts, and an optional bus watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module zap_wb_arbiter_n #(
    parameter int NUM_MASTERS    = 3,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,

    input  logic [NUM_MASTERS-1:0]   i_wb_cyc_nxt,
    input  logic [NUM_MASTERS-1:0]   i_wb_stb_nxt,
    input  logic [NUM_MASTERS-1:0]   i_wb_wen_nxt,
    input  logic [4*NUM_MASTERS-1:0] i_wb_sel_nxt,
    input  logic [32*NUM_MASTERS-1:0] i_wb_adr_nxt,
    input  logic [32*NUM_MASTERS-1:0] i_wb_dat_nxt,
    input  logic [3*NUM_MASTERS-1:0] i_wb_cti_nxt,

    output logic [NUM_MASTERS-1:0]   o_wb_ack,
    output logic [NUM_MASTERS-1:0]   o_wb_err,

    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_wen,
    output logic [3:0]               o_wb_sel,
    output logic [31:0]              o_wb_adr,
    output logic [31:0]              o_wb_dat,
    output logic [2:0]               o_wb_cti,

    output logic                     o_wb_cyc_nxt,
    output logic                     o_wb_stb_nxt,
    output logic                     o_wb_wen_nxt,
    output logic [3:0]               o_wb_sel_nxt,
    output logic [31:0]              o_wb_adr_nxt,
    output logic [31:0]              o_wb_dat_nxt,
    output logic [2:0]               o_wb_cti_nxt,

    input  logic                     i_wb_ack,
    input  logic                     i_wb_err,

    output logic [NUM_MASTERS-1:0]   o_grant,
    output logic                     o_timeout
);

    localparam logic [NUM_MASTERS-1:0] c_ONE     = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [2:0]             c_CTI_EOB = 3'b111;

    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_arb_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic                   w_expire;
    logic                   w_rearb;
    logic                   w_lock;

    assign o_grant   = r_grant;
    assign o_timeout = w_expire;

    // Re-arbitration window: idle bus, completed beat, or watchdog kill.
    assign w_rearb = !o_wb_stb || i_wb_ack || w_expire;

    // The lock only holds while the current owner actually has the bus, so a
    // master that is merely reset-granted cannot block a higher-priority one.
    assign w_lock  = o_wb_cyc && (|(r_grant & i_wb_cyc_nxt)) && !w_expire;

    generate
        if (ARB_MODE == 0) begin : g_fixed
            // Highest-index requester wins: later loop iterations override.
            always_comb begin
                w_arb_grant = r_grant;
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    if (i_wb_cyc_nxt[k]) w_arb_grant = c_ONE << k;
                end
            end
        end else begin : g_rr
            logic [3:0] w_cur_idx;

            // One-hot to index for the current owner.
            always_comb begin
                w_cur_idx = 4'd0;
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    if (r_grant[k]) w_cur_idx = 4'(k);
                end
            end

            // Search downward so the closest requester above the owner wins.
            always_comb begin
                w_arb_grant = r_grant;
                for (int off = NUM_MASTERS; off >= 1; off--) begin
                    if (i_wb_cyc_nxt[(int'(w_cur_idx) + off) % NUM_MASTERS])
                        w_arb_grant = c_ONE << ((int'(w_cur_idx) + off) % NUM_MASTERS);
                end
            end
        end
    endgenerate

    // Next grant: keep owner unless arbitration is open and unlocked.
    always_comb begin
        w_grant_nxt = r_grant;
        if (w_rearb && !w_lock && (|i_wb_cyc_nxt)) w_grant_nxt = w_arb_grant;
    end

    // Select the next-cycle bus from the master chosen by the next grant.
    always_comb begin
        o_wb_cyc_nxt = 1'b0;
        o_wb_stb_nxt = 1'b0;
        o_wb_wen_nxt = 1'b0;
        o_wb_sel_nxt = 4'd0;
        o_wb_adr_nxt = 32'd0;
        o_wb_dat_nxt = 32'd0;
        o_wb_cti_nxt = c_CTI_EOB;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (w_grant_nxt[k]) begin
                o_wb_cyc_nxt = i_wb_cyc_nxt[k];
                o_wb_stb_nxt = i_wb_stb_nxt[k];
                o_wb_wen_nxt = i_wb_wen_nxt[k];
                o_wb_sel_nxt = i_wb_sel_nxt[k*4 +: 4];
                o_wb_adr_nxt = i_wb_adr_nxt[k*32 +: 32];
                o_wb_dat_nxt = i_wb_dat_nxt[k*32 +: 32];
                o_wb_cti_nxt = i_wb_cti_nxt[k*3 +: 3];
            end
        end
        if (w_expire) begin
            o_wb_cyc_nxt = 1'b0;
            o_wb_stb_nxt = 1'b0;
        end
    end

    // Route slave responses to the current owner; a watchdog kill looks like
    // an error-terminated beat. Nothing is routed while reset is asserted.
    always_comb begin
        o_wb_ack = '0;
        o_wb_err = '0;
        if (i_reset_n && (i_wb_ack || w_expire))
            o_wb_ack = r_grant;
        if (i_reset_n && ((i_wb_ack && i_wb_err) || w_expire))
            o_wb_err = r_grant;
    end

    // Grant register and registered slave-side bus.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_grant  <= c_ONE;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_sel <= 4'd0;
            o_wb_adr <= 32'd0;
            o_wb_dat <= 32'd0;
            o_wb_cti <= c_CTI_EOB;
        end else begin
            r_grant  <= w_grant_nxt;
            o_wb_cyc <= o_wb_cyc_nxt;
            o_wb_stb <= o_wb_stb_nxt;
            o_wb_wen <= o_wb_wen_nxt;
            o_wb_sel <= o_wb_sel_nxt;
            o_wb_adr <= o_wb_adr_nxt;
            o_wb_dat <= o_wb_dat_nxt;
            o_wb_cti <= o_wb_cti_nxt;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdt
            logic [15:0] r_wdt_cnt;

            assign w_expire = o_wb_stb && !i_wb_ack &&
                              (r_wdt_cnt == 16'(TIMEOUT_CYCLES - 1));

            // Count stalled strobe cycles; any ACK, idle or kill restarts it.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n)
                    r_wdt_cnt <= 16'd0;
                else if (!o_wb_stb || i_wb_ack || w_expire)
                    r_wdt_cnt <= 16'd0;
                else
                    r_wdt_cnt <= r_wdt_cnt + 16'd1;
            end
        end else begin : g_no_wdt
            assign w_expire = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_zap_wb_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zap_wb_arbiter_n
//  Description : Self-checking bench for zap_wb_arbiter_n: fixed priority,
//                lock, error routing, watchdog, round-robin and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_wb_arbiter_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // ---------------- DUT A: N=3, fixed priority, watchdog 8 ----------------
    logic [2:0]  a_cyc, a_stb, a_wen;
    logic [11:0] a_sel;
    logic [95:0] a_adr, a_dat;
    logic [8:0]  a_cti;
    logic [2:0]  a_ack_o, a_err_o, a_grant;
    logic        a_cyc_o, a_stb_o, a_wen_o, a_cyc_n, a_stb_n, a_wen_n;
    logic [3:0]  a_sel_o, a_sel_n;
    logic [31:0] a_adr_o, a_dat_o, a_adr_n, a_dat_n;
    logic [2:0]  a_cti_o, a_cti_n;
    logic        a_ack, a_err, a_tmo;

    zap_wb_arbiter_n #(.NUM_MASTERS(3), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc_nxt(a_cyc), .i_wb_stb_nxt(a_stb), .i_wb_wen_nxt(a_wen),
        .i_wb_sel_nxt(a_sel), .i_wb_adr_nxt(a_adr), .i_wb_dat_nxt(a_dat),
        .i_wb_cti_nxt(a_cti),
        .o_wb_ack(a_ack_o), .o_wb_err(a_err_o),
        .o_wb_cyc(a_cyc_o), .o_wb_stb(a_stb_o), .o_wb_wen(a_wen_o),
        .o_wb_sel(a_sel_o), .o_wb_adr(a_adr_o), .o_wb_dat(a_dat_o), .o_wb_cti(a_cti_o),
        .o_wb_cyc_nxt(a_cyc_n), .o_wb_stb_nxt(a_stb_n), .o_wb_wen_nxt(a_wen_n),
        .o_wb_sel_nxt(a_sel_n), .o_wb_adr_nxt(a_adr_n), .o_wb_dat_nxt(a_dat_n),
        .o_wb_cti_nxt(a_cti_n),
        .i_wb_ack(a_ack), .i_wb_err(a_err),
        .o_grant(a_grant), .o_timeout(a_tmo)
    );

    // ---------------- DUT B: N=4, round-robin, no watchdog ------------------
    logic [3:0]   b_cyc, b_stb, b_wen;
    logic [15:0]  b_sel;
    logic [127:0] b_adr, b_dat;
    logic [11:0]  b_cti;
    logic [3:0]   b_ack_o, b_err_o, b_grant;
    logic         b_cyc_o, b_stb_o, b_wen_o, b_cyc_n, b_stb_n, b_wen_n;
    logic [3:0]   b_sel_o, b_sel_n;
    logic [31:0]  b_adr_o, b_dat_o, b_adr_n, b_dat_n;
    logic [2:0]   b_cti_o, b_cti_n;
    logic         b_ack, b_err, b_tmo;

    zap_wb_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(1), .TIMEOUT_CYCLES(0)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc_nxt(b_cyc), .i_wb_stb_nxt(b_stb), .i_wb_wen_nxt(b_wen),
        .i_wb_sel_nxt(b_sel), .i_wb_adr_nxt(b_adr), .i_wb_dat_nxt(b_dat),
        .i_wb_cti_nxt(b_cti),
        .o_wb_ack(b_ack_o), .o_wb_err(b_err_o),
        .o_wb_cyc(b_cyc_o), .o_wb_stb(b_stb_o), .o_wb_wen(b_wen_o),
        .o_wb_sel(b_sel_o), .o_wb_adr(b_adr_o), .o_wb_dat(b_dat_o), .o_wb_cti(b_cti_o),
        .o_wb_cyc_nxt(b_cyc_n), .o_wb_stb_nxt(b_stb_n), .o_wb_wen_nxt(b_wen_n),
        .o_wb_sel_nxt(b_sel_n), .o_wb_adr_nxt(b_adr_n), .o_wb_dat_nxt(b_dat_n),
        .o_wb_cti_nxt(b_cti_n),
        .i_wb_ack(b_ack), .i_wb_err(b_err),
        .o_grant(b_grant), .o_timeout(b_tmo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  cyc;     // cyc and stb driven identically
        logic        ack;
        logic        err;
        logic [2:0]  e_ack;   // routed ACK before the edge
        logic [2:0]  e_err;   // routed ERR before the edge
        logic [2:0]  e_grant; // after the edge
        logic        e_stb;   // after the edge
        logic [31:0] e_adr;   // after the edge (low nibble = master index)
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          idx;
        int          rr_exp[5];
        logic [3:0]  oh;

        // Fixed-priority arbitration, burst lock and ACK/ERR routing.
        vecs[0]  = '{cyc:3'b101, ack:1'b0, err:1'b0, e_ack:3'b000, e_err:3'b000, e_grant:3'b100, e_stb:1'b1, e_adr:32'hA000_0002};
        vecs[1]  = '{cyc:3'b101, ack:1'b1, err:1'b0, e_ack:3'b100, e_err:3'b000, e_grant:3'b100, e_stb:1'b1, e_adr:32'hA000_0002};
        vecs[2]  = '{cyc:3'b001, ack:1'b1, err:1'b0, e_ack:3'b100, e_err:3'b000, e_grant:3'b001, e_stb:1'b1, e_adr:32'hA000_0000};
        vecs[3]  = '{cyc:3'b001, ack:1'b0, err:1'b1, e_ack:3'b000, e_err:3'b000, e_grant:3'b001, e_stb:1'b1, e_adr:32'hA000_0000};
        vecs[4]  = '{cyc:3'b101, ack:1'b1, err:1'b1, e_ack:3'b001, e_err:3'b001, e_grant:3'b001, e_stb:1'b1, e_adr:32'hA000_0000};
        vecs[5]  = '{cyc:3'b101, ack:1'b1, err:1'b0, e_ack:3'b001, e_err:3'b000, e_grant:3'b001, e_stb:1'b1, e_adr:32'hA000_0000};
        vecs[6]  = '{cyc:3'b100, ack:1'b1, err:1'b0, e_ack:3'b001, e_err:3'b000, e_grant:3'b100, e_stb:1'b1, e_adr:32'hA000_0002};
        vecs[7]  = '{cyc:3'b000, ack:1'b1, err:1'b0, e_ack:3'b100, e_err:3'b000, e_grant:3'b100, e_stb:1'b0, e_adr:32'hA000_0002};
        vecs[8]  = '{cyc:3'b010, ack:1'b0, err:1'b0, e_ack:3'b000, e_err:3'b000, e_grant:3'b010, e_stb:1'b1, e_adr:32'hA000_0001};
        vecs[9]  = '{cyc:3'b010, ack:1'b1, err:1'b1, e_ack:3'b010, e_err:3'b010, e_grant:3'b010, e_stb:1'b1, e_adr:32'hA000_0001};
        vecs[10] = '{cyc:3'b000, ack:1'b1, err:1'b0, e_ack:3'b010, e_err:3'b000, e_grant:3'b010, e_stb:1'b0, e_adr:32'hA000_0001};

        rr_exp = '{1, 2, 3, 0, 1};

        // Per-master payloads: master k -> adr A000_000k, dat D000_000k,
        // sel k+1, cti k, wen set for masters 0 and 2.
        a_cyc = '0; a_stb = '0; a_wen = 3'b101; a_ack = 1'b0; a_err = 1'b0;
        b_cyc = '0; b_stb = '0; b_wen = '0;     b_ack = 1'b0; b_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                a_adr[k*32 +: 32] = 32'hA000_0000 + 32'(k);
                a_dat[k*32 +: 32] = 32'hD000_0000 + 32'(k);
                a_sel[k*4 +: 4]   = 4'(k + 1);
                a_cti[k*3 +: 3]   = 3'(k);
            end
            b_adr[k*32 +: 32] = 32'hA000_0000 + 32'(k);
            b_dat[k*32 +: 32] = 32'hD000_0000 + 32'(k);
            b_sel[k*4 +: 4]   = 4'(k + 1);
            b_cti[k*3 +: 3]   = 3'(k);
        end

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(a_grant), 32'h1);
        check("rst_cyc_stb", {30'd0, a_cyc_o, a_stb_o}, 32'h0);
        check("rst_adr", a_adr_o, 32'h0);
        check("rst_cti", 32'(a_cti_o), 32'h7);
        check("rst_grant_b", 32'(b_grant), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors on DUT A
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            a_cyc = vecs[i].cyc;
            a_stb = vecs[i].cyc;
            a_ack = vecs[i].ack;
            a_err = vecs[i].err;
            #1;
            check($sformatf("v%0d_ack", i), 32'(a_ack_o), 32'(vecs[i].e_ack));
            check($sformatf("v%0d_err", i), 32'(a_err_o), 32'(vecs[i].e_err));
            @(posedge clk);
            #1;
            idx = int'(vecs[i].e_adr[3:0]);
            check($sformatf("v%0d_grant", i), 32'(a_grant), 32'(vecs[i].e_grant));
            check($sformatf("v%0d_stb", i), 32'(a_stb_o), 32'(vecs[i].e_stb));
            check($sformatf("v%0d_adr", i), a_adr_o, vecs[i].e_adr);
            check($sformatf("v%0d_dat", i), a_dat_o, 32'hD000_0000 + 32'(idx));
            check($sformatf("v%0d_cti", i), 32'(a_cti_o), 32'(idx));
        end

        // Watchdog: slave never ACKs, expiry on the 8th strobe cycle
        @(negedge clk);
        a_cyc = 3'b001; a_stb = 3'b001; a_ack = 1'b0; a_err = 1'b0;
        @(posedge clk);
        #1;
        check("wdt_grant", 32'(a_grant), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("wdt_tmo_c%0d", i), 32'(a_tmo), (i == 8) ? 32'h1 : 32'h0);
            if (i == 8) begin
                check("wdt_ack", 32'(a_ack_o), 32'h1);
                check("wdt_err", 32'(a_err_o), 32'h1);
                check("wdt_stb_nxt", 32'(a_stb_n), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        check("wdt_stb_after", 32'(a_stb_o), 32'h0);
        check("wdt_tmo_after", 32'(a_tmo), 32'h0);

        // Real ACK arriving in the would-be expiry cycle wins
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin
                a_ack = 1'b1;
                #1;
                check("wdt_race_tmo", 32'(a_tmo), 32'h0);
                check("wdt_race_ack", 32'(a_ack_o), 32'h1);
                check("wdt_race_err", 32'(a_err_o), 32'h0);
            end else begin
                check($sformatf("wdt2_tmo_c%0d", i), 32'(a_tmo), 32'h0);
            end
            @(posedge clk);
            #1;
        end

        // Round-robin on DUT B: each master does one single-beat cycle
        @(negedge clk);
        b_cyc = 4'b1110; b_stb = 4'b1110; b_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            oh = 4'(1 << rr_exp[i]);
            check($sformatf("rr_grant%0d", i), 32'(b_grant), 32'(oh));
            check($sformatf("rr_adr%0d", i), b_adr_o, 32'hA000_0000 + 32'(rr_exp[i]));
            @(negedge clk);
            b_cyc = ~oh; b_stb = ~oh; b_ack = 1'b1;
        end

        // Asynchronous reset mid-burst on DUT A (master 0 still holding the bus)
        @(negedge clk);
        a_cyc = 3'b001; a_stb = 3'b001; a_ack = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_stb", 32'(a_stb_o), 32'h1);
        a_ack = 1'b1; a_err = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(a_grant), 32'h1);
        check("arst_cyc_stb_wen", {29'd0, a_cyc_o, a_stb_o, a_wen_o}, 32'h0);
        check("arst_sel", 32'(a_sel_o), 32'h0);
        check("arst_adr", a_adr_o, 32'h0);
        check("arst_dat", a_dat_o, 32'h0);
        check("arst_cti", 32'(a_cti_o), 32'h7);
        check("arst_ack", 32'(a_ack_o), 32'h0);
        check("arst_err", 32'(a_err_o), 32'h0);
        check("arst_tmo", 32'(a_tmo), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zap_wb_arbiter_n.md
ZAP_WB_ARBITER_N -- requirements
Module: zap_wb_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, meaning number of Wishbone masters (range 2..8).
REQ-002 SHALL have parameter ARB_MODE, default 0, meaning 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0, meaning bus-watchdog limit in cycles (16-bit range); 0 disables the watchdog.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports i_wb_cyc_nxt, i_wb_stb_nxt, i_wb_wen_nxt  input  NUM_MASTERS each  per-master next-cycle CYC/STB/WE; bit k belongs to master k.
REQ-007 SHALL have ports i_wb_sel_nxt (4*NUM_MASTERS), i_wb_adr_nxt (32*NUM_MASTERS), i_wb_dat_nxt (32*NUM_MASTERS), i_wb_cti_nxt (3*NUM_MASTERS)  input  per-master fields packed, master k at slice [k*W +: W].
REQ-008 SHALL have ports o_wb_ack, o_wb_err  output  NUM_MASTERS  per-master routed ACK/ERR.
REQ-009 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_wen (1), o_wb_sel (4), o_wb_adr (32), o_wb_dat (32), o_wb_cti (3)  output  registered bus to slave.
REQ-010 SHALL have matching *_nxt outputs  output  same widths  combinational values that the registered bus takes next edge.
REQ-011 SHALL have ports i_wb_ack, i_wb_err  input  1  slave ACK/ERR.
REQ-012 SHALL have port o_grant  output  NUM_MASTERS  one-hot current grant (grant_ff).
REQ-013 SHALL have port o_timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 SHALL hold one-hot grant_ff; grant_nxt is computed only when re-arbitration is permitted: !o_wb_stb, or o_wb_stb && i_wb_ack, or watchdog expiry; otherwise grant_nxt = grant_ff.
REQ-015 SHALL keep grant_nxt = grant_ff when re-arbitration is permitted and the granted master's i_wb_cyc_nxt is 1 (bus lock across bursts), except after watchdog expiry.
REQ-016 SHALL, in ARB_MODE 0 when not locked, grant the highest-index master with i_wb_cyc_nxt = 1.
REQ-017 SHALL, in ARB_MODE 1 when not locked, grant the first requesting master searching upward from (current index + 1) mod NUM_MASTERS and wrapping.
REQ-018 SHALL keep grant_ff unchanged when no master requests.
REQ-019 SHALL drive *_nxt outputs from the master selected by grant_nxt; registered outputs SHALL load *_nxt each edge (one-cycle latency).
REQ-020 SHALL route i_wb_ack to o_wb_ack[g] and i_wb_err && i_wb_ack to o_wb_err[g], where g = grant_ff; all other bits SHALL be 0.
REQ-021 SHALL ignore i_wb_err when i_wb_ack = 0 (no routing).
REQ-022 SHALL, when TIMEOUT_CYCLES > 0, count cycles with o_wb_stb = 1 and i_wb_ack = 0, and clear the count on ACK or when o_wb_stb = 0.
REQ-023 SHALL, when the count reaches TIMEOUT_CYCLES-1 with no ACK, assert o_wb_ack[g] = o_wb_err[g] = o_timeout = 1 for that cycle, force o_wb_cyc_nxt = o_wb_stb_nxt = 0, clear the count, and release the lock.
REQ-024 SHALL give a real i_wb_ack arriving in the expiry cycle priority: normal ACK routing, no timeout.
REQ-025 SHALL pass CTI unmodified; a master's CTI_EOB (3'b111) does not itself end the lock (CYC does).

Reset
REQ-026 SHALL, while i_reset_n = 0, force grant_ff = one-hot master 0, o_wb_cyc = o_wb_stb = o_wb_wen = 0, o_wb_sel = 0, o_wb_adr = 0, o_wb_dat = 0, o_wb_cti = 3'b111, watchdog count = 0, o_timeout = 0.
REQ-027 SHALL abandon any in-flight transfer on reset without generating ACK/ERR to any master.

Verification
REQ-028 Mode 0, N=3: masters 0 and 2 raise cyc/stb together -> master 2 granted, o_wb_adr = master-2 address one cycle later; master 0 served after master 2 drops cyc.
REQ-029 Mode 1, N=4: all masters request continuously with single-beat cycles -> grants 1,2,3,0,1 in order.
REQ-030 Lock: master 0 4-beat burst (cyc held), master 2 raises cyc at beat 2 -> no switch until master 0 cyc = 0.
REQ-031 TIMEOUT_CYCLES=8: slave never ACKs -> o_timeout, o_wb_ack[g], o_wb_err[g] pulse on 8th stb cycle; o_wb_stb = 0 next cycle.
REQ-032 i_wb_err = 1 with i_wb_ack = 0 -> no o_wb_err bit set; i_wb_err = i_wb_ack = 1 -> only o_wb_err[g] = 1.
REQ-033 i_reset_n low mid-burst -> outputs take REQ-026 values immediately (asynchronously), o_grant = 1.
